counter_stream_checker: RTL and testbench

//  In-fabric checker that consumes the 8-bit outCounter stream of the counter top and verifies each sample

---
 rtl/counter_check_pkg.sv | 18 +
 rtl/sat_counter.sv | 26 ++
 rtl/counter_stream_checker.sv | 121 ++++++++++++
 tb/tb_counter_stream_checker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_check_pkg.sv
// Shared state encoding and default parameters for the counter stream checker.
package counter_check_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StSync  = ST_SYNC,
    StCheck = ST_CHECK
  } chk_state_e;

  localparam int unsigned DefWidth       = 8;
  localparam int unsigned DefStep        = 1;
  localparam int unsigned DefErrCntWidth = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/counter_stream_checker.sv
// Checks that each valid sample equals the previous one plus STEP; reports pulses, a sticky
// fail flag, saturating statistics and the first failing expected/actual pair.
module counter_stream_checker
  import counter_check_pkg::*;
#(
  parameter int unsigned WIDTH         = DefWidth,
  parameter int unsigned STEP          = DefStep,
  parameter int unsigned ERR_CNT_WIDTH = DefErrCntWidth
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic                     i_clear,
  input  logic                     i_in_valid,
  input  logic [WIDTH-1:0]         i_in_counter,
  output logic                     o_locked,
  output logic                     o_mismatch,
  output logic                     o_fail,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count,
  output logic [ERR_CNT_WIDTH-1:0] o_checked_count,
  output logic [WIDTH-1:0]         o_first_expected,
  output logic [WIDTH-1:0]         o_first_actual
);

  localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

  chk_state_e       r_state;
  logic [WIDTH-1:0] r_prev;
  logic             r_locked;
  logic             r_mismatch;
  logic             r_fail;
  logic [WIDTH-1:0] r_first_expected;
  logic [WIDTH-1:0] r_first_actual;

  logic [WIDTH-1:0] w_expected;
  logic             w_compare;
  logic             w_bad;

  assign w_expected = r_prev + StepW;
  // Clear and disable both suppress the compare for this sample.
  assign w_compare  = (r_state == StCheck) && i_in_valid && i_enable && !i_clear;
  assign w_bad      = w_compare && (i_in_counter != w_expected);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= StIdle;
      r_prev           <= '0;
      r_locked         <= 1'b0;
      r_mismatch       <= 1'b0;
      r_fail           <= 1'b0;
      r_first_expected <= '0;
      r_first_actual   <= '0;
    end else begin
      r_mismatch <= 1'b0;
      if (i_clear) begin
        r_state          <= i_enable ? StSync : StIdle;
        r_prev           <= '0;
        r_locked         <= 1'b0;
        r_fail           <= 1'b0;
        r_first_expected <= '0;
        r_first_actual   <= '0;
      end else if (!i_enable) begin
        r_state  <= StIdle;
        r_locked <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: r_state <= StSync;
          StSync: begin
            if (i_in_valid) begin
              r_prev   <= i_in_counter;
              r_locked <= 1'b1;
              r_state  <= StCheck;
            end
          end
          StCheck: begin
            if (i_in_valid) begin
              // Resync to the actual value so a single jump costs a single error.
              r_prev <= i_in_counter;
              if (w_bad) begin
                r_mismatch <= 1'b1;
                r_fail     <= 1'b1;
                if (!r_fail) begin
                  r_first_expected <= w_expected;
                  r_first_actual   <= i_in_counter;
                end
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  sat_counter #(
    .W (ERR_CNT_WIDTH)
  ) u_err_count (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_bad),
    .i_clr   (i_clear),
    .o_q     (o_err_count)
  );

  sat_counter #(
    .W (ERR_CNT_WIDTH)
  ) u_checked_count (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_compare),
    .i_clr   (i_clear),
    .o_q     (o_checked_count)
  );

  assign o_locked         = r_locked;
  assign o_mismatch       = r_mismatch;
  assign o_fail           = r_fail;
  assign o_first_expected = r_first_expected;
  assign o_first_actual   = r_first_actual;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Bench: fixed vector table, hand-written corner sequences and a random stream, all compared
// against a behavioural model; a second instance with 4-bit counts exercises saturation.
module tb_counter_stream_checker;
  import counter_check_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, clr = 1'b0, vld = 1'b0;
  logic [7:0] din = 8'h00;

  logic        a_lk, a_mm, a_fl;
  logic [15:0] a_err, a_chk;
  logic [7:0]  a_fe, a_fa;
  logic        b_lk, b_mm, b_fl;
  logic [3:0]  b_err, b_chk;
  logic [7:0]  b_fe, b_fa;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  counter_stream_checker #(.WIDTH(8), .STEP(1), .ERR_CNT_WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_clear(clr), .i_in_valid(vld),
    .i_in_counter(din), .o_locked(a_lk), .o_mismatch(a_mm), .o_fail(a_fl),
    .o_err_count(a_err), .o_checked_count(a_chk), .o_first_expected(a_fe),
    .o_first_actual(a_fa)
  );

  counter_stream_checker #(.WIDTH(8), .STEP(1), .ERR_CNT_WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_clear(clr), .i_in_valid(vld),
    .i_in_counter(din), .o_locked(b_lk), .o_mismatch(b_mm), .o_fail(b_fl),
    .o_err_count(b_err), .o_checked_count(b_chk), .o_first_expected(b_fe),
    .o_first_actual(b_fa)
  );

  // Behavioural model: "listening" means enable has been seen for a full cycle.
  bit   m_listen, m_seeded, m_fail, m_mm;
  int   m_prev, m_fe, m_fa;
  int   e16, c16, e4, c4;

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic model_reset();
    m_listen = 0; m_seeded = 0; m_fail = 0; m_mm = 0;
    m_prev = 0; m_fe = 0; m_fa = 0;
    e16 = 0; c16 = 0; e4 = 0; c4 = 0;
  endtask

  task automatic model_step(input bit e, input bit c, input bit v, input int d);
    int expv;
    m_mm = 0;
    if (c) begin
      e16 = 0; c16 = 0; e4 = 0; c4 = 0;
      m_fail = 0; m_fe = 0; m_fa = 0; m_seeded = 0; m_listen = e;
    end else if (!e) begin
      m_listen = 0; m_seeded = 0;
    end else if (!m_listen) begin
      m_listen = 1;
    end else if (v) begin
      if (!m_seeded) begin
        m_seeded = 1;
      end else begin
        expv = (m_prev + DefStep) % 256;
        c16 = sat_inc(c16, 65535);
        c4  = sat_inc(c4, 15);
        if (d != expv) begin
          m_mm = 1;
          e16 = sat_inc(e16, 65535);
          e4  = sat_inc(e4, 15);
          if (!m_fail) begin
            m_fe = expv; m_fa = d;
          end
          m_fail = 1;
        end
      end
      m_prev = d;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_all();
    check("a_locked",   32'(a_lk),  32'(m_seeded));
    check("a_mismatch", 32'(a_mm),  32'(m_mm));
    check("a_fail",     32'(a_fl),  32'(m_fail));
    check("a_err",      32'(a_err), 32'(e16));
    check("a_checked",  32'(a_chk), 32'(c16));
    check("a_first_exp", 32'(a_fe), 32'(m_fe));
    check("a_first_act", 32'(a_fa), 32'(m_fa));
    check("b_mismatch", 32'(b_mm),  32'(m_mm));
    check("b_fail",     32'(b_fl),  32'(m_fail));
    check("b_err",      32'(b_err), 32'(e4));
    check("b_checked",  32'(b_chk), 32'(c4));
    check("b_first_act", 32'(b_fa), 32'(m_fa));
  endtask

  task automatic step(input bit e, input bit c, input bit v, input logic [7:0] d);
    @(negedge clk);
    en = e; clr = c; vld = v; din = d;
    @(posedge clk);
    model_step(e, c, v, int'(d));
    #1;
    check_all();
  endtask

  typedef struct {
    bit         e, c, v;
    logic [7:0] d;
    bit         lk, mm, fl;
    int         err, chk;
    logic [7:0] fe, fa;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit e, input bit c, input bit v, input logic [7:0] d,
                              input bit lk, input bit mm, input bit fl, input int err,
                              input int chk, input logic [7:0] fe, input logic [7:0] fa);
    vec_t r;
    r.e = e; r.c = c; r.v = v; r.d = d; r.lk = lk; r.mm = mm; r.fl = fl;
    r.err = err; r.chk = chk; r.fe = fe; r.fa = fa;
    return r;
  endfunction

  initial begin
    logic [7:0] last;
    bit e, c, v;
    logic [7:0] d;

    // Straight count, wrap-free
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    for (int i = 0; i <= 5; i++)
      tbl.push_back(mk(1, 0, 1, 8'(i), 1, 0, 0, 0, i, 8'h00, 8'h00));
    // Single jump
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h01, 1, 0, 0, 0, 1, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h14, 1, 1, 1, 1, 2, 8'h02, 8'h14));
    tbl.push_back(mk(1, 0, 1, 8'h15, 1, 0, 1, 1, 3, 8'h02, 8'h14));
    // Clear beats in_valid; next sample is the seed
    tbl.push_back(mk(1, 1, 1, 8'h40, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h41, 1, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h42, 1, 0, 0, 0, 1, 8'h00, 8'h00));
    // Wrap through 0xFF
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'hFD, 1, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'hFE, 1, 0, 0, 0, 1, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'hFF, 1, 0, 0, 0, 2, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 3, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h01, 1, 0, 0, 0, 4, 8'h00, 8'h00));
    // Disable drops lock, keeps stats; re-enable costs an idle cycle then a seed
    tbl.push_back(mk(0, 0, 1, 8'h01, 0, 0, 0, 0, 4, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h02, 0, 0, 0, 0, 4, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h10, 1, 0, 0, 0, 4, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h11, 1, 0, 0, 0, 5, 8'h00, 8'h00));

    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].e, tbl[i].c, tbl[i].v, tbl[i].d);
      check("t_locked",   32'(a_lk),  32'(tbl[i].lk));
      check("t_mismatch", 32'(a_mm),  32'(tbl[i].mm));
      check("t_fail",     32'(a_fl),  32'(tbl[i].fl));
      check("t_err",      32'(a_err), 32'(tbl[i].err));
      check("t_checked",  32'(a_chk), 32'(tbl[i].chk));
      check("t_first_exp", 32'(a_fe), 32'(tbl[i].fe));
      check("t_first_act", 32'(a_fa), 32'(tbl[i].fa));
    end

    // Saturation of the 4-bit instance on a stuck stream
    step(1, 1, 0, 8'h00);
    step(1, 0, 1, 8'h33);
    for (int i = 0; i < 20; i++) step(1, 0, 1, 8'h33);
    check("sat_b_err", 32'(b_err), 32'h0000_000F);
    check("sat_b_fail", 32'(b_fl), 32'd1);
    check("sat_b_first_act", 32'(b_fa), 32'h33);
    check("sat_b_first_exp", 32'(b_fe), 32'h34);
    check("sat_a_err", 32'(a_err), 32'd20);

    // Async reset mid-stream, then a fresh seed
    step(1, 1, 0, 8'h00);
    step(1, 0, 1, 8'h0E);
    step(1, 0, 1, 8'h0F);
    step(1, 0, 1, 8'h10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 8'h00);
    step(1, 0, 1, 8'h80);
    step(1, 0, 1, 8'h81);
    check("rst_checked", 32'(a_chk), 32'd1);
    check("rst_mismatch", 32'(a_mm), 32'd0);
    check("rst_locked", 32'(a_lk), 32'd1);

    // Random stream: mostly incrementing, occasional jumps, disables and clears
    last = 8'h81;
    for (int i = 0; i < 600; i++) begin
      e = ($urandom_range(0, 15) != 0);
      c = ($urandom_range(0, 31) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : last + 8'h01;
      if (v) last = d;
      step(e, c, v, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
